// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : UART transmitter with input word FIFO, configurable data width,
//             parity mode and stop-bit count, paced by an external baud tick.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 enb,
   output logic                 tx,
   output logic                 busy,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow
);

   localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_LOAD   = 3'd1;
   localparam logic [2:0] c_ST_START  = 3'd2;
   localparam logic [2:0] c_ST_DATA   = 3'd3;
   localparam logic [2:0] c_ST_PARITY = 3'd4;
   localparam logic [2:0] c_ST_STOP   = 3'd5;

   localparam logic [3:0] c_LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic [1:0] c_LAST_STOP = 2'(STOP_BITS - 1);
   localparam logic       c_ODD       = (PARITY_MODE == 2);

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [c_ADDR_W-1:0]  r_wr_ptr;
   logic [c_ADDR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_CNT_W-1:0]   w_count_nxt;
   logic                 r_full;
   logic                 r_empty;
   logic                 r_overflow;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_busy;
   logic [DATA_BITS-1:0] w_head;

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic [3:0]           r_bitcnt;
   logic [1:0]           r_stopcnt;
   logic                 r_tx;

   // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
   assign w_push = wr_en & ~r_full;
   assign w_head = r_mem[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == c_CNT_W'(FIFO_DEPTH));
         r_empty    <= (w_count_nxt == '0);
         r_overflow <= wr_en & r_full;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:   if (!r_empty) w_state_nxt = c_ST_LOAD;
         c_ST_LOAD:   w_state_nxt = c_ST_START;
         c_ST_START:  if (enb) w_state_nxt = c_ST_DATA;
         c_ST_DATA:   if (enb && r_bitcnt == c_LAST_BIT)
                         w_state_nxt = (PARITY_MODE != 0) ? c_ST_PARITY : c_ST_STOP;
         c_ST_PARITY: if (enb) w_state_nxt = c_ST_STOP;
         c_ST_STOP:   if (enb && r_stopcnt == c_LAST_STOP) w_state_nxt = c_ST_IDLE;
         default:     w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_pop  = (r_state == c_ST_IDLE) & ~r_empty;
      w_busy = (r_state != c_ST_IDLE) | ~r_empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx      <= 1'b1;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_bitcnt  <= '0;
         r_stopcnt <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: if (w_pop) begin
               r_shift   <= w_head;
               r_parity  <= (^w_head) ^ c_ODD;
               r_bitcnt  <= '0;
               r_stopcnt <= '0;
            end
            c_ST_START:  if (enb) r_tx <= 1'b0;
            c_ST_DATA:   if (enb) begin
               r_tx     <= r_shift[0];
               r_shift  <= r_shift >> 1;
               r_bitcnt <= r_bitcnt + 4'd1;
            end
            c_ST_PARITY: if (enb) r_tx <= r_parity;
            c_ST_STOP:   if (enb) begin
               r_tx      <= 1'b1;
               r_stopcnt <= r_stopcnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign tx       = r_tx;
   assign busy     = w_busy;
   assign full     = r_full;
   assign empty    = r_empty;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed self-checking bench for uart_tx_fifo (8N1, 7E2, 7O2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic       enb;
   logic       wr0, wr1, wr2;
   logic [7:0] data0;
   logic [6:0] data1, data2;
   logic       tx0, busy0, full0, empty0, ovf0;
   logic       tx1, busy1, full1, empty1, ovf1;
   logic       tx2, busy2, full2, empty2, ovf2;
   logic       tx_sel;
   int         sel;
   int         checks;
   int         errors;

   uart_tx_fifo u_dut_8n1 (
      .clk(clk), .rst(rst), .wr_en(wr0), .data_in(data0), .enb(enb),
      .tx(tx0), .busy(busy0), .full(full0), .empty(empty0), .overflow(ovf0)
   );

   uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_dut_7e2 (
      .clk(clk), .rst(rst), .wr_en(wr1), .data_in(data1), .enb(enb),
      .tx(tx1), .busy(busy1), .full(full1), .empty(empty1), .overflow(ovf1)
   );

   uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_7o2 (
      .clk(clk), .rst(rst), .wr_en(wr2), .data_in(data2), .enb(enb),
      .tx(tx2), .busy(busy2), .full(full2), .empty(empty2), .overflow(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      case (sel)
         1:       tx_sel = tx1;
         2:       tx_sel = tx2;
         default: tx_sel = tx0;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit i of 'bits' is tx right after the i-th enb pulse; 'stable' drops if tx moves between pulses.
   task automatic run_bits(input int n, input int gmin, input int gmax,
                           output logic [63:0] bits, output bit stable);
      logic last;
      bits   = '0;
      stable = 1'b1;
      last   = tx_sel;
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = (gmin == gmax) ? gmin : int'($urandom_range(gmax, gmin));
         repeat (gap - 1) begin
            tick();
            if (tx_sel !== last) stable = 1'b0;
         end
         enb = 1'b1;
         tick();
         enb = 1'b0;
         bits[i] = tx_sel;
         last    = tx_sel;
      end
   endtask

   task automatic write0(input logic [7:0] d);
      data0 = d;
      wr0   = 1'b1;
      tick();
      wr0   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (tx0 !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b expected 1", tx0); end
      checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
      checks++; if (full0 !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b expected 0", full0); end
      checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty0); end
      checks++; if (ovf0 !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf0); end
      checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL reset_tx_7e2: got %b expected 1", tx1); end
   endtask

   task automatic test_8n1();
      logic [63:0] bits;
      bit          stable;
      sel = 0;
      write0(8'hA5);
      checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL 8n1_empty_after_write: got %b expected 0", empty0); end
      checks++; if (busy0 !== 1'b1)  begin errors++; $display("FAIL 8n1_busy_after_write: got %b expected 1", busy0); end
      run_bits(10, 16, 16, bits, stable);
      checks++; if (bits[9:0] !== 10'b1101001010) begin errors++; $display("FAIL 8n1_frame: got %b expected %b", bits[9:0], 10'b1101001010); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL 8n1_busy_after_stop: got %b expected 0", busy0); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL 8n1_tx_stable: got %b expected 1", stable); end
   endtask

   task automatic test_parity();
      logic [63:0] bits;
      bit          stable;
      sel = 1;
      data1 = 7'h35; wr1 = 1'b1; tick(); wr1 = 1'b0;
      run_bits(11, 8, 8, bits, stable);
      checks++; if (bits[10:0] !== 11'b11001101010) begin errors++; $display("FAIL 7e2_frame: got %b expected %b", bits[10:0], 11'b11001101010); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL 7e2_busy_after_stop: got %b expected 0", busy1); end
      sel = 2;
      data2 = 7'h35; wr2 = 1'b1; tick(); wr2 = 1'b0;
      run_bits(11, 8, 8, bits, stable);
      checks++; if (bits[10:0] !== 11'b11101101010) begin errors++; $display("FAIL 7o2_frame: got %b expected %b", bits[10:0], 11'b11101101010); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL 7o2_busy_after_stop: got %b expected 0", busy2); end
      sel = 0;
   endtask

   task automatic test_fifo_fill();
      logic [63:0] bits;
      logic [9:0]  exp;
      bit          stable;
      sel = 0;
      enb = 1'b0;
      wr0 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         data0 = 8'(k);
         tick();
      end
      checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full0); end
      checks++; if (ovf0 !== 1'b0)  begin errors++; $display("FAIL fill_no_overflow: got %b expected 0", ovf0); end
      data0 = 8'h06;
      tick();
      wr0 = 1'b0;
      checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL fill_overflow_pulse: got %b expected 1", ovf0); end
      tick();
      checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL fill_overflow_one_cycle: got %b expected 0", ovf0); end
      run_bits(50, 4, 4, bits, stable);
      for (int k = 0; k < 5; k++) begin
         exp = {1'b1, 8'(k + 1), 1'b0};
         checks++; if (bits[10*k +: 10] !== exp) begin errors++; $display("FAIL fill_frame%0d: got %b expected %b", k, bits[10*k +: 10], exp); end
      end
      checks++; if (empty0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL fill_drained: got empty=%b busy=%b expected empty=1 busy=0", empty0, busy0); end
   endtask

   task automatic test_full_pop();
      logic [63:0] bits;
      bit          stable;
      sel = 0;
      enb = 1'b0;
      wr0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         data0 = 8'h11 + 8'(k);
         tick();
      end
      wr0 = 1'b0;
      checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b expected 1", full0); end
      run_bits(9, 4, 4, bits, stable);
      enb = 1'b1; tick(); enb = 1'b0;
      data0 = 8'h77; wr0 = 1'b1; tick(); wr0 = 1'b0;
      checks++; if (ovf0 !== 1'b1)   begin errors++; $display("FAIL fullpop_overflow: got %b expected 1", ovf0); end
      checks++; if (full0 !== 1'b0)  begin errors++; $display("FAIL fullpop_full_after_pop: got %b expected 0", full0); end
      checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", empty0); end
      run_bits(40, 4, 4, bits, stable);
      checks++;
      if (bits[39:0] !== {1'b1, 8'h15, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h12, 1'b0}) begin
         errors++;
         $display("FAIL fullpop_frames: got %h expected %h", bits[39:0],
                  {1'b1, 8'h15, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h12, 1'b0});
      end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL fullpop_busy_end: got %b expected 0", busy0); end
   endtask

   task automatic test_mid_reset();
      logic [63:0] bits;
      bit          stable;
      sel = 0;
      enb = 1'b0;
      wr0 = 1'b1;
      data0 = 8'h00; tick();
      data0 = 8'hFF; tick();
      data0 = 8'hFF; tick();
      wr0 = 1'b0;
      run_bits(5, 4, 4, bits, stable);
      checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL midrst_tx_before: got %b expected 0", tx0); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (tx0 !== 1'b1)    begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx0); end
      checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
      checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty0); end
      checks++; if (full0 !== 1'b0)  begin errors++; $display("FAIL midrst_full: got %b expected 0", full0); end
      run_bits(30, 4, 4, bits, stable);
      checks++; if (bits[29:0] !== {30{1'b1}} || stable !== 1'b1) begin errors++; $display("FAIL midrst_line_idle: got %b stable=%b expected all ones", bits[29:0], stable); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy0); end
   endtask

   task automatic test_sparse();
      logic [63:0] bits;
      bit          stable;
      sel = 0;
      write0(8'hA5);
      run_bits(10, 3, 40, bits, stable);
      checks++; if (bits[9:0] !== 10'b1101001010) begin errors++; $display("FAIL sparse_frame: got %b expected %b", bits[9:0], 10'b1101001010); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL sparse_tx_stable: got %b expected 1", stable); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] bits;
      bit          stable;
      sel = 0;
      write0(8'h3C);
      write0(8'hC3);
      run_bits(20, 3, 3, bits, stable);
      checks++;
      if (bits[19:0] !== {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}) begin
         errors++;
         $display("FAIL b2b_frames: got %b expected %b", bits[19:0], {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0});
      end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy0); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sel    = 0;
      rst    = 1'b1;
      enb    = 1'b0;
      wr0    = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
      data0  = '0;   data1 = '0; data2 = '0;
      test_reset();
      test_8n1();
      test_parity();
      test_fifo_fill();
      test_full_pop();
      test_mid_reset();
      test_sparse();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
